// File: rtl/multiword_adder.sv
// Word-serial adder: {oC,oS} = iA + iB + iC, one WORD_WIDTH slice per cycle, result NW cycles after accept.
// Accepts only in IDLE; the result is held in DONE until iReady, followed by one IDLE bubble.

module carry_chain_adder #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WIDTH = 8
) (
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    output logic [WIDTH-1:0] oS,
    output logic             oC
);
    localparam int NB = WIDTH / BLOCK_WIDTH;

    logic                 chain;
    logic [BLOCK_WIDTH:0] blk_sum;

    // Byte-sized blocks rippled through a single variable keeps the chain acyclic.
    always_comb begin
        oS      = '0;
        chain   = iC;
        blk_sum = '0;
        for (int g = 0; g < NB; g++) begin
            blk_sum = {1'b0, iA[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                    + {1'b0, iB[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                    + {{BLOCK_WIDTH{1'b0}}, chain};
            oS[g*BLOCK_WIDTH +: BLOCK_WIDTH] = blk_sum[BLOCK_WIDTH-1:0];
            chain = blk_sum[BLOCK_WIDTH];
        end
        oC = chain;
    end
endmodule

module multiword_adder #(
    parameter int WIDTH      = 128,
    parameter int WORD_WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oS,
    output logic             oC
);
    localparam int NW = WIDTH / WORD_WIDTH;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state;
    logic [CW-1:0]                cnt;
    logic [WIDTH-1:0]             a_q;
    logic [WIDTH-1:0]             b_q;
    logic [WIDTH-1:0]             sum_q;
    logic                         carry_q;
    logic                         ready_q;
    logic                         valid_q;
    logic [WORD_WIDTH-1:0]        word_sum;
    logic                         word_carry;
    logic [WIDTH+WORD_WIDTH-1:0]  sum_cat;

    carry_chain_adder #(
        .WIDTH       (WORD_WIDTH),
        .BLOCK_WIDTH (8)
    ) u_word_add (
        .iA (a_q[WORD_WIDTH-1:0]),
        .iB (b_q[WORD_WIDTH-1:0]),
        .iC (carry_q),
        .oS (word_sum),
        .oC (word_carry)
    );

    // New word enters at the MSB end; after NW shifts word 0 sits at the LSBs.
    assign sum_cat = {word_sum, sum_q};

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iValid) begin
                        a_q     <= iA;
                        b_q     <= iB;
                        carry_q <= iC;
                        cnt     <= '0;
                        state   <= RUN;
                        ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_cat[WIDTH+WORD_WIDTH-1:WORD_WIDTH];
                    a_q     <= a_q >> WORD_WIDTH;
                    b_q     <= b_q >> WORD_WIDTH;
                    carry_q <= word_carry;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (iReady) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign oReady = ready_q;
    assign oValid = valid_q;
    assign oS     = sum_q;
    assign oC     = carry_q;
endmodule

// File: tb/tb_multiword_adder.sv
// Scoreboard bench for multiword_adder: accepted requests queue a reference sum, a monitor checks each result.
module tb_multiword_adder;
    localparam int WIDTH = 128;
    localparam int WW    = 32;
    localparam int NW    = WIDTH / WW;

    logic             iClk   = 1'b0;
    logic             iRstN  = 1'b0;
    logic             iValid = 1'b0;
    logic             iC     = 1'b0;
    logic             iReady = 1'b1;
    logic [WIDTH-1:0] iA     = '0;
    logic [WIDTH-1:0] iB     = '0;
    logic             oReady;
    logic             oValid;
    logic [WIDTH-1:0] oS;
    logic             oC;

    multiword_adder #(.WIDTH(WIDTH), .WORD_WIDTH(WW)) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iValid (iValid),
        .oReady (oReady),
        .iA     (iA),
        .iB     (iB),
        .iC     (iC),
        .oValid (oValid),
        .iReady (iReady),
        .oS     (oS),
        .oC     (oC)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [WIDTH:0] sum;
        int             acc;
    } exp_t;

    exp_t           exp_q[$];
    int             vstart_q[$];
    exp_t           e;
    int             checks     = 0;
    int             failures   = 0;
    int             cyc        = 0;
    int             valid_seen = 0;
    bit             held       = 0;
    bit             rnd_ready  = 0;
    logic [WIDTH:0] held_val;

    always @(posedge iClk) cyc++;

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic c);
        return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
    endfunction

    function automatic logic [WIDTH-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_sum(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor and accept tracker, sampled mid-cycle.
    always @(negedge iClk) begin
        if (!iRstN) begin
            held = 0;
        end else begin
            if (oValid) begin
                valid_seen++;
                if (!held) begin
                    check_bit("pending_expect", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_sum("result", {oC, oS}, e.sum);
                        check_int("latency", cyc - e.acc, NW);
                    end
                    vstart_q.push_back(cyc);
                    held     = 1;
                    held_val = {oC, oS};
                end else begin
                    check_sum("hold_stable", {oC, oS}, held_val);
                end
                check_bit("ready_low_in_done", oReady, 1'b0);
                if (iReady) held = 0;
            end
            if (iValid && oReady) exp_q.push_back('{ref_add(iA, iB, iC), cyc + 1});
        end
    end

    always @(posedge iClk) begin
        if (rnd_ready) begin
            #1 iReady = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         input bit hold_valid = 0);
        bit ok = 0;
        iA = a;
        iB = b;
        iC = c;
        iValid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge iClk);
            if (oReady) begin
                ok = 1;
                break;
            end
        end
        check_bit("accept_in_time", ok, 1'b1);
        tick();
        if (!hold_valid) iValid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge iClk);
            if (exp_q.size() == 0 && !oValid && oReady) begin
                ok = 1;
                break;
            end
        end
        check_bit("drain_in_time", ok, 1'b1);
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        int               seen0;

        tick(2);
        @(negedge iClk);
        check_bit("reset_ready", oReady, 1'b1);
        check_bit("reset_valid", oValid, 1'b0);
        check_sum("reset_sum", {oC, oS}, '0);

        // Release and request in the same cycle: accept must land on the first edge.
        @(posedge iClk);
        #1;
        iRstN = 1'b1;
        issue({WIDTH{1'b1}}, 128'd1, 1'b0);
        wait_idle();
        issue(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0);
        wait_idle();
        issue('0, '0, 1'b1);
        wait_idle();
        pat = 128'h1234_5678_9ABC_DEF0_FEDC_BA98_7654_3210;
        issue(pat, ~pat, 1'b1);
        wait_idle();

        // Backpressure with stray requests while busy.
        iReady = 1'b0;
        issue(rand128(), rand128(), 1'b1);
        for (int k = 0; k < NW + 5; k++) begin
            iA = rand128();
            iB = rand128();
            iC = 1'b0;
            iValid = (k % 2 == 0);
            @(negedge iClk);
            check_bit("busy_ready_low", oReady, 1'b0);
            tick();
        end
        @(negedge iClk);
        check_bit("bp_valid_held", oValid, 1'b1);
        tick();
        iValid = 1'b0;
        iReady = 1'b1;
        wait_idle();

        // Reset two cycles after accept.
        issue(rand128(), rand128(), 1'b1);
        tick();
        iRstN = 1'b0;
        exp_q.delete();
        @(negedge iClk);
        check_bit("midrst_valid", oValid, 1'b0);
        check_bit("midrst_ready", oReady, 1'b1);
        check_sum("midrst_sum", {oC, oS}, '0);
        tick();
        iRstN = 1'b1;
        seen0 = valid_seen;
        tick(12);
        check_int("no_result_after_reset", valid_seen - seen0, 0);

        // Back-to-back with iValid/iReady held high.
        vstart_q.delete();
        issue(rand128(), rand128(), 1'b0, 1);
        issue({WIDTH{1'b1}}, {WIDTH{1'b1}}, 1'b1, 1);
        issue(rand128(), rand128(), 1'b1, 0);
        wait_idle();
        check_int("b2b_count", vstart_q.size(), 3);
        if (vstart_q.size() == 3) begin
            check_int("b2b_gap1", vstart_q[1] - vstart_q[0], NW + 2);
            check_int("b2b_gap2", vstart_q[2] - vstart_q[1], NW + 2);
        end

        // Random operands under random consumer backpressure.
        rnd_ready = 1;
        for (int n = 0; n < 24; n++) begin
            issue(rand128(), (n % 5 == 0) ? ~iA : rand128(), ($urandom_range(0, 1) == 1));
        end
        rnd_ready = 0;
        tick();
        iReady = 1'b1;
        wait_idle();

        check_int("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/multiword_adder.md
MULTIWORD_ADDER -- requirements
Module: multiword_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 128: total operand width; an integer multiple of WORD_WIDTH.
REQ-002 SHALL have parameter WORD_WIDTH, default 32: width added per cycle; a multiple of 8.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port iClk  input  1: rising-edge clock.
REQ-005 SHALL have port iRstN  input  1: asynchronous active-low reset.
REQ-006 SHALL have port iValid  input  1: operand request valid.
REQ-007 SHALL have port oReady  output  1: block can accept operands.
REQ-008 SHALL have port iA  input  WIDTH: operand A.
REQ-009 SHALL have port iB  input  WIDTH: operand B.
REQ-010 SHALL have port iC  input  1: carry-in.
REQ-011 SHALL have port oValid  output  1: result valid.
REQ-012 SHALL have port iReady  input  1: consumer accepts the result.
REQ-013 SHALL have port oS  output  WIDTH: sum.
REQ-014 SHALL have port oC  output  1: carry-out.

Function
REQ-015 SHALL compute {oC,oS} = iA + iB + iC, modulo 2^(WIDTH+1), over NW = WIDTH/WORD_WIDTH cycles.
REQ-016 SHALL perform each word addition with one carry_chain_adder instance, WIDTH=WORD_WIDTH, BLOCK_WIDTH=8.
REQ-017 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-018 SHALL drive oReady=1 only in IDLE.
REQ-019 SHALL treat an edge with state IDLE and iValid=1 as the accept edge.
REQ-020 On the accept edge, the block SHALL capture iA/iB into shift registers, load carry register with iC, clear word counter, and enter RUN.
REQ-021 SHALL ignore iValid and operand inputs outside IDLE.
REQ-022 In each RUN cycle, the block SHALL add the low operand words plus the carry register.
REQ-023 At the end of each RUN cycle, the block SHALL shift the word sum into the sum register from the MSB end, shift the operands right by WORD_WIDTH, set carry register to adder oC, and increment the counter.
REQ-024 SHALL go from RUN to DONE on the edge that completes word NW-1 (counter==NW-1).
REQ-025 SHALL make oValid=1 exactly NW cycles after the accept edge.
REQ-026 SHALL assert oValid only in DONE.
REQ-027 SHALL drive oS from the sum register and oC from the carry register at all times.
REQ-028 SHALL hold oS and oC stable while in DONE.
REQ-029 SHALL go from DONE to IDLE on an edge with iReady=1.
REQ-030 While iReady=0, DONE SHALL hold indefinitely.
REQ-031 SHALL have a minimum initiation interval of NW+2 cycles: one IDLE bubble after each handshake, with no overlap.
REQ-032 SHALL handle the NW=1 case: RUN lasts one cycle.
REQ-033 SHALL propagate carries across word boundaries only through the carry register, never combinationally between words.

Reset
REQ-034 While iRstN=0, state SHALL be IDLE, with counter, shift registers, sum register and carry register all 0.
REQ-035 Under reset, outputs SHALL be oReady=1, oValid=0, oS=0, oC=0.
REQ-036 Reset asserted in RUN or DONE SHALL abort the operation with no oValid pulse.
REQ-037 After reset release, the first accept SHALL be possible on the first rising edge.

Verification (WIDTH=128, WORD_WIDTH=32)
REQ-038 Full carry ripple: iA=all ones, iB=1, iC=0 -> oS=0, oC=1, oValid exactly 4 cycles after the accept edge.
REQ-039 Word-boundary carry: iA=0x...0000_FFFFFFFF, iB=1, iC=0 -> oS=0x...0001_00000000, oC=0.
REQ-040 Carry-in only: iA=iB=0, iC=1 -> oS=1, oC=0; also iA=0x1234..., iB=~iA, iC=1 -> oS=0, oC=1.
REQ-041 Backpressure: hold iReady=0 for 5 cycles after oValid, and pulse iValid with new operands during RUN/DONE -> oValid, oS and oC remain stable, and the new operands are ignored.
REQ-042 Reset mid-operation: drop iRstN two cycles after accept -> oValid=0, oS=0, oC=0, oReady=1, and no result appears after release.
REQ-043 Back-to-back: iValid=1 and iReady=1 held for 3 operations -> 3 correct results with spacing NW+2 = 6 cycles, matching a reference model.
